// File: rtl/instr_fetch_sequencer_if.sv
// Fetch sequencer bus: control, memory and IR byte-bus signals.
// master = sequencer side, slave = environment (memory/IR/control).
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              Start;
  logic              PCLoad;
  logic [ADDR_W-1:0] PCIn;
  logic [7:0]        MemData;
  logic              MemReady;
  logic              MemRead;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        IR_I;
  logic              IR_LH;
  logic              IR_Write;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Done;
  logic              Fault;

  modport master (
    input  Start, PCLoad, PCIn,
    input  MemData, MemReady,
    output MemRead, MemAddr,
    output IR_I, IR_LH, IR_Write,
    output PC, Busy, Done, Fault
  );

  modport slave (
    output Start, PCLoad, PCIn,
    output MemData, MemReady,
    input  MemRead, MemAddr,
    input  IR_I, IR_LH, IR_Write,
    input  PC, Busy, Done, Fault
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Two-byte instruction fetch sequencer; owns the PC, drives IR bytes.
// Ports: i_clk, i_rst (async high), io_bus (master modport).
// Optional FETCH_TIMEOUT_EN: per-byte wait limit with Fault pulse.
module instr_fetch_sequencer #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  instr_fetch_sequencer_if.master io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_rd;
  logic              w_wr;
  logic              w_lh;
  logic              w_done;
  logic              w_fetch;
  logic              w_tmo;

  assign w_fetch = (r_state == ST_LO) ||
                   (r_state == ST_HI);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // Abort only when the limit is reached with no data;
  // data arriving in that same cycle still wins.
  assign w_tmo = w_fetch && !io_bus.MemReady &&
                 (r_cnt == CW'(TIMEOUT_CYCLES));

  always_comb begin
    w_cnt_next = '0;
    if (w_fetch && !io_bus.MemReady && !w_tmo)
      w_cnt_next = r_cnt + CW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_next;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_tmo        = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_lh      = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Load first so a same-cycle Start uses PCIn.
        if (io_bus.PCLoad) w_pc_next = io_bus.PCIn;
        if (io_bus.Start)  w_next    = ST_LO;
      end
      ST_LO: begin
        w_rd = 1'b1;
        w_wr = io_bus.MemReady;
        if (io_bus.MemReady) begin
          w_pc_next = r_pc + ADDR_W'(1);
          w_next    = ST_HI;
        end else if (w_tmo) begin
          w_next = ST_IDLE;
        end
      end
      ST_HI: begin
        w_rd = 1'b1;
        w_lh = 1'b1;
        w_wr = io_bus.MemReady;
        if (io_bus.MemReady) begin
          w_pc_next = r_pc + ADDR_W'(1);
          w_next    = ST_DONE;
        end else if (w_tmo) begin
          w_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
    end
  end

  assign io_bus.MemRead  = w_rd;
  assign io_bus.MemAddr  = r_pc;
  assign io_bus.IR_I     = io_bus.MemData;
  assign io_bus.IR_LH    = w_lh;
  assign io_bus.IR_Write = w_wr;
  assign io_bus.PC       = r_pc;
  assign io_bus.Busy     = (r_state != ST_IDLE);
  assign io_bus.Done     = w_done;
  assign io_bus.Fault    = w_tmo;

endmodule
